conv_window_gen: RTL
====================

// Module: conv_window_gen
// PURPOSE
//   Sits directly downstream of the 8-bit input FIFO and feeds the conv engine.
//   Drains one image frame (IMG_W x IMG_H pixels, raster order) from the FIFO,
//   keeps the previous two rows in internal line buffers, and emits one 3x3
//   window per valid output position (valid padding) over a valid/ready handshake.
//   Throughput is one pixel per clock when the FIFO is non-empty and the consumer is ready.
// PARAMETERS
//   DATA_W  8  pixel width, matching the FIFO data width
//   IMG_W   8  frame width in pixels, >= 3
//   IMG_H   8  frame height in pixels, >= 3
// PORTS
//   clk         in   1               rising-edge clock
//   reset       in   1               asynchronous, active-high reset
//   start       in   1               1-cycle pulse; begins a frame when IDLE, ignored otherwise
//   en          in   1               0 = suppress new fifo_rd (pause); handshake still runs
//   fifo_empty  in   1               FIFO empty flag
//   fifo_rd     out  1               FIFO read strobe
//   fifo_data   in   DATA_W          FIFO dataOut, valid in the cycle after fifo_rd
//   win_valid   out  1               window valid
//   win_ready   in   1               consumer accepts a window when win_valid & win_ready
//   win_data    out  9*DATA_W        w0..w8 row-major, w0 = top-left at [DATA_W-1:0], w8 = newest pixel
//   win_row     out  clog2(IMG_H)    top-left row of the window
//   win_col     out  clog2(IMG_W)    top-left column of the window
//   frame_done  out  1               1-cycle pulse after the last window is accepted
//   busy        out  1               high in every state except IDLE
// BEHAVIOUR
//   Reset: all outputs are 0, state = IDLE, all counters are 0. Line-buffer contents are not reset.
//   FSM:
//     IDLE -> RUN on start.
//     RUN -> FLUSH when pixel IMG_W*IMG_H-1 is consumed.
//     FLUSH -> DONE when no window is pending (win_valid = 0, or win_valid & win_ready).
//     DONE -> IDLE after 1 cycle; frame_done = 1 only in DONE.
//   stall = win_valid & ~win_ready.
//   rd_q = fifo_rd registered, meaning a pixel arrives this cycle.
//   Read request: fifo_rd = RUN & en & ~fifo_empty & ~stall & ~hold_v & (req_cnt < IMG_W*IMG_H).
//     req_cnt counts issued reads.
//   Hold register: a pixel that arrives (rd_q) while stall = 1 is captured in hold and sets hold_v.
//     At most one pixel is ever held.
//   Consume: when stall = 0, the block consumes hold if hold_v, otherwise the arriving pixel if rd_q.
//     Consuming hold clears hold_v. No pixel is ever dropped or duplicated.
//   Per consumed pixel p at position (r,c):
//     - Shift the window one column left; new right column = {lb1[c], lb0[c], p} (top to bottom).
//     - Update line buffers: lb1[c] <= lb0[c], lb0[c] <= p.
//     - Advance c; on wrap c = 0 and r increments.
//   Output register: win_valid <= 1 on a consume with r >= 2 and c >= 2, with win_row = r-2 and win_col = c-2.
//     Otherwise win_valid clears on handshake.
//     win_data, win_row and win_col are held stable while stall = 1.
//   Latency: fifo_rd in cycle n -> pixel consumed at the end of cycle n+1 -> win_valid high in cycle n+2
//     (no stall).
//   Count: exactly (IMG_W-2)*(IMG_H-2) windows and exactly IMG_W*IMG_H fifo_rd pulses per frame.
//   Boundaries:
//     - fifo_empty or en = 0: reads pause; a pixel already in flight is still consumed.
//     - Columns 0-1 of every row and rows 0-1 produce no window.
//     - Column wrap needs no bubble.
//     - start while busy is ignored.
//     - reset mid-frame aborts immediately to IDLE; the next start re-fetches a whole frame.
// TESTING
//   T1 Reset: hold reset across clocks -> all outputs 0, busy = 0; release, no start -> fifo_rd stays 0.
//   T2 8x8 frame, pixels 0..63, FIFO never empty, win_ready = 1:
//      - 64 fifo_rd pulses and 36 windows.
//      - First window (0,0) = {0,1,2,8,9,10,16,17,18}.
//      - Last window (5,5) = {45,46,47,53,54,55,61,62,63}.
//      - One frame_done pulse, then busy = 0.
//   T3 Backpressure: drop win_ready for 3 cycles at window (2,3), then randomly at 50%:
//      - win_data is held stable during stalls.
//      - The window sequence is identical to T2 and hold never overflows.
//   T4 FIFO starvation plus en: fifo_empty toggled pseudo-randomly, en = 0 for 5 cycles mid-row:
//      - No fifo_rd while empty or en = 0.
//      - The sequence is identical to T2.
//   T5 Reset mid-frame after 20 pixels:
//      - All outputs go to 0 asynchronously and the FSM returns to IDLE.
//      - A new start with pixels 100..163 gives first window {100,101,102,108,109,110,116,117,118}.
//   T6 start pulsed during RUN and FLUSH is ignored: no counter restart and the window count stays 36.

Source files
------------

// File: rtl/conv_window_gen.sv
// Streams one raster-order frame from the input FIFO through two line buffers
// and presents every fully populated 3x3 window (valid padding) to the conv engine.
module conv_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       en,
  input  logic                       fifo_empty,
  output logic                       fifo_rd,
  input  logic [DATA_W-1:0]          fifo_data,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [9*DATA_W-1:0]        win_data,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       frame_done,
  output logic                       busy,
  output logic [1:0]                 state_dbg
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int REQ_W = $clog2(NPIX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic               rd_q;
  logic [REQ_W-1:0]   req_cnt;
  logic [ROW_W-1:0]   r;
  logic [COL_W-1:0]   c;
  logic [DATA_W-1:0]  hold;
  logic               hold_v;
  logic [DATA_W-1:0]  w   [9];
  logic [DATA_W-1:0]  lb0 [IMG_W];
  logic [DATA_W-1:0]  lb1 [IMG_W];

  logic               stall;
  logic               consume;
  logic               last_pix;
  logic [DATA_W-1:0]  pix;

  // Window handshake: a window transfers on the rising edge where win_valid and
  // win_ready are both high; while win_valid is high and win_ready low, the
  // window (data, row, col) is frozen and no new pixel is consumed.
  assign stall    = win_valid & ~win_ready;
  assign consume  = (state == ST_RUN) & ~stall & (hold_v | rd_q);
  assign pix      = hold_v ? hold : fifo_data;
  assign last_pix = (r == ROW_W'(IMG_H - 1)) && (c == COL_W'(IMG_W - 1));

  assign frame_done = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);
  assign state_dbg  = state;

  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        fifo_rd = en & ~fifo_empty & ~stall & ~hold_v & (req_cnt < REQ_W'(NPIX));
        if (consume && last_pix) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: if (~win_valid | win_ready) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < 9; i++) win_data[i*DATA_W +: DATA_W] = w[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rd_q      <= 1'b0;
      req_cnt   <= '0;
      r         <= '0;
      c         <= '0;
      hold      <= '0;
      hold_v    <= 1'b0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      for (int i = 0; i < 9; i++) w[i] <= '0;
    end else begin
      state <= state_nxt;
      rd_q  <= fifo_rd;

      if (state == ST_IDLE && start) begin
        req_cnt <= '0;
        r       <= '0;
        c       <= '0;
        hold_v  <= 1'b0;
      end else if (fifo_rd) begin
        req_cnt <= req_cnt + REQ_W'(1);
      end

      // A pixel landing during a stall parks here; reads stop until it drains.
      if (state == ST_RUN && rd_q && stall) begin
        hold   <= fifo_data;
        hold_v <= 1'b1;
      end else if (consume && hold_v) begin
        hold_v <= 1'b0;
      end

      if (consume) begin
        for (int i = 0; i < 3; i++) begin
          w[i*3]     <= w[i*3+1];
          w[i*3 + 1] <= w[i*3+2];
        end
        w[2] <= lb1[c];
        w[5] <= lb0[c];
        w[8] <= pix;
        if (c == COL_W'(IMG_W - 1)) begin
          c <= '0;
          r <= r + ROW_W'(1);
        end else begin
          c <= c + COL_W'(1);
        end
      end

      if (consume && r >= ROW_W'(2) && c >= COL_W'(2)) begin
        win_valid <= 1'b1;
        win_row   <= r - ROW_W'(2);
        win_col   <= c - COL_W'(2);
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

  // Line buffers hold image data only, so they carry no reset.
  always_ff @(posedge clk) begin
    if (consume) begin
      lb1[c] <= lb0[c];
      lb0[c] <= pix;
    end
  end

endmodule
